// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Brief    : Shared types and helpers for the local/global/chooser predictors.
// Revision : 1.0
// ============================================================================
package bp_pkg;

    // Widest counter the helpers support; callers truncate to their own width.
    localparam int unsigned CTR_MAX_W = 16;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_state_e;

    function automatic logic [CTR_MAX_W-1:0] ctr_sat_update(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int unsigned          width
    );
        logic [CTR_MAX_W-1:0] one;
        logic [CTR_MAX_W-1:0] max_val;
        one     = CTR_MAX_W'(1);
        max_val = (one << width) - one;
        if (taken) begin
            return (ctr == max_val) ? ctr : ctr + one;
        end
        return (ctr == '0) ? ctr : ctr - one;
    endfunction

    function automatic logic [CTR_MAX_W-1:0] weak_not_taken(input int unsigned width);
        logic [CTR_MAX_W-1:0] one;
        one = CTR_MAX_W'(1);
        return (one << (width - 1)) - one;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_table_init.sv
`default_nettype none
// ============================================================================
// Module   : bp_table_init
// Brief    : Post-reset table sweep: one address per cycle, then RUN/ready.
// Revision : 1.0
// ============================================================================
module bp_table_init
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    output logic              ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o
);

    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    init_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_o = 1'b0;
        wr_en_o = 1'b0;
        case (state_q)
            ST_INIT: begin
                // Writes are held off while reset is low so a reset cycle never touches the tables.
                wr_en_o = reset_ni;
                ptr_d   = ptr_q + ADDR_W'(1);
                if (ptr_q == C_LAST) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end
            end
            ST_RUN: begin
                ready_o = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign wr_addr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/local_predictor_param.sv
`default_nettype none
// ============================================================================
// Module   : local_predictor_param
// Brief    : Parametrised local-history predictor (LHT + LPT) with update bypass.
// Revision : 1.0
// ============================================================================
module local_predictor_param
    import bp_pkg::*;
#(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned LHT_ENTRIES = 1024,
    parameter int unsigned HIST_W      = 10,
    parameter int unsigned CTR_W       = 3
) (
    input  logic            clock,
    input  logic            reset,
    output logic            ready,
    input  logic            pred_valid,
    input  logic [PC_W-1:0] pred_pc,
    output logic            pred_out_valid,
    output logic            pred_taken,
    output logic            pred_conf,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    output logic [31:0]     upd_count,
    output logic [31:0]     hit_count
);

    localparam int unsigned IDX_W      = $clog2(LHT_ENTRIES);
    localparam int unsigned LPT_DEPTH  = 1 << HIST_W;
    localparam int unsigned INIT_DEPTH = (LHT_ENTRIES > LPT_DEPTH) ? LHT_ENTRIES : LPT_DEPTH;
    localparam int unsigned PTR_W      = $clog2(INIT_DEPTH);

    localparam logic [CTR_W-1:0] C_WEAK_NT = CTR_W'(weak_not_taken(CTR_W));
    localparam logic [PTR_W:0]   C_LHT_LIM = (PTR_W + 1)'(LHT_ENTRIES);
    localparam logic [PTR_W:0]   C_LPT_LIM = (PTR_W + 1)'(LPT_DEPTH);

    logic [HIST_W-1:0] lht_q [LHT_ENTRIES];
    logic [CTR_W-1:0]  lpt_q [LPT_DEPTH];

    logic              init_wr_en;
    logic [PTR_W-1:0]  init_addr;

    bp_table_init #(
        .DEPTH  (INIT_DEPTH),
        .ADDR_W (PTR_W)
    ) u_init (
        .clock_i   (clock),
        .reset_ni  (reset),
        .ready_o   (ready),
        .wr_en_o   (init_wr_en),
        .wr_addr_o (init_addr)
    );

    logic              upd_fire, pred_fire;
    logic [IDX_W-1:0]  upd_idx, pred_idx;
    logic [HIST_W-1:0] upd_hist, upd_hist_new, pred_hist;
    logic [CTR_W-1:0]  upd_ctr, upd_ctr_new, pred_ctr;
    logic              upd_hit;

    always_comb begin
        upd_fire     = upd_valid & ready & reset;
        pred_fire    = pred_valid & ready & reset;
        upd_idx      = upd_pc[IDX_W-1:0];
        pred_idx     = pred_pc[IDX_W-1:0];
        upd_hist     = lht_q[upd_idx];
        upd_ctr      = lpt_q[upd_hist];
        upd_hist_new = {upd_hist[HIST_W-2:0], upd_taken};
        upd_ctr_new  = CTR_W'(ctr_sat_update(CTR_MAX_W'(upd_ctr), upd_taken, CTR_W));
        upd_hit      = (upd_ctr[CTR_W-1] == upd_taken);

        // Prediction observes this cycle's update: history first, then the counter it selects.
        pred_hist = lht_q[pred_idx];
        if (upd_fire && (upd_idx == pred_idx)) begin
            pred_hist = upd_hist_new;
        end
        pred_ctr = lpt_q[pred_hist];
        if (upd_fire && (upd_hist == pred_hist)) begin
            pred_ctr = upd_ctr_new;
        end
    end

    // Tables carry no reset; the sweep rewrites every entry before ready rises.
    always_ff @(posedge clock) begin
        if (init_wr_en) begin
            if ({1'b0, init_addr} < C_LHT_LIM) begin
                lht_q[init_addr[IDX_W-1:0]] <= '0;
            end
            if ({1'b0, init_addr} < C_LPT_LIM) begin
                lpt_q[init_addr[HIST_W-1:0]] <= C_WEAK_NT;
            end
        end else if (upd_fire) begin
            lht_q[upd_idx]  <= upd_hist_new;
            lpt_q[upd_hist] <= upd_ctr_new;
        end
    end

    logic        pred_out_valid_q, pred_out_valid_d;
    logic        pred_taken_q, pred_taken_d;
    logic        pred_conf_q, pred_conf_d;
    logic [31:0] upd_count_q, upd_count_d;
    logic [31:0] hit_count_q, hit_count_d;

    always_comb begin
        pred_out_valid_d = pred_fire;
        pred_taken_d     = pred_taken_q;
        pred_conf_d      = pred_conf_q;
        upd_count_d      = upd_count_q;
        hit_count_d      = hit_count_q;
        if (pred_fire) begin
            pred_taken_d = pred_ctr[CTR_W-1];
            pred_conf_d  = (pred_ctr == '0) || (pred_ctr == '1);
        end
        if (upd_fire && (upd_count_q != '1)) begin
            upd_count_d = upd_count_q + 32'd1;
        end
        if (upd_fire && upd_hit && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_conf_q      <= 1'b0;
            upd_count_q      <= '0;
            hit_count_q      <= '0;
        end else begin
            pred_out_valid_q <= pred_out_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_conf_q      <= pred_conf_d;
            upd_count_q      <= upd_count_d;
            hit_count_q      <= hit_count_d;
        end
    end

    assign pred_out_valid = pred_out_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_conf      = pred_conf_q;
    assign upd_count      = upd_count_q;
    assign hit_count      = hit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_local_predictor_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_local_predictor_param
// Brief    : Randomised + directed bench against an array-based predictor model.
// Revision : 1.0
// ============================================================================
module tb_local_predictor_param;

    localparam int PC_W     = 10;
    localparam int LHT_N    = 1024;
    localparam int HIST_W   = 10;
    localparam int CTR_W    = 3;
    localparam int LPT_N    = 1 << HIST_W;
    localparam int INIT_LEN = (LHT_N > LPT_N) ? LHT_N : LPT_N;
    localparam int CTR_MAX  = (1 << CTR_W) - 1;
    localparam int CTR_HALF = 1 << (CTR_W - 1);

    logic            clock;
    logic            reset;
    logic            ready;
    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_out_valid;
    logic            pred_taken;
    logic            pred_conf;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [31:0]     upd_count;
    logic [31:0]     hit_count;

    local_predictor_param #(
        .PC_W        (PC_W),
        .LHT_ENTRIES (LHT_N),
        .HIST_W      (HIST_W),
        .CTR_W       (CTR_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ready          (ready),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .pred_conf      (pred_conf),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_count      (upd_count),
        .hit_count      (hit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays, state updated once per rising edge.
    int          m_lht [LHT_N];
    int          m_lpt [LPT_N];
    bit          m_ready   = 0;
    int          m_initcnt = 0;
    bit          m_pov     = 0;
    bit          m_taken   = 0;
    bit          m_conf    = 0;
    int unsigned m_upd     = 0;
    int unsigned m_hit     = 0;

    task automatic model_step();
        int h, c, i;
        if (reset !== 1'b1) begin
            m_ready = 0; m_initcnt = 0; m_pov = 0; m_taken = 0; m_conf = 0;
            m_upd = 0; m_hit = 0;
        end else if (!m_ready) begin
            m_pov = 0;
            m_initcnt++;
            if (m_initcnt == INIT_LEN) begin
                foreach (m_lht[k]) m_lht[k] = 0;
                foreach (m_lpt[k]) m_lpt[k] = CTR_HALF - 1;
                m_ready = 1;
            end
        end else begin
            if (upd_valid) begin
                i = int'(upd_pc) % LHT_N;
                h = m_lht[i];
                c = m_lpt[h];
                m_upd++;
                if ((c >= CTR_HALF) == bit'(upd_taken)) m_hit++;
                if (upd_taken) m_lpt[h] = (c < CTR_MAX) ? c + 1 : c;
                else           m_lpt[h] = (c > 0) ? c - 1 : c;
                m_lht[i] = ((h * 2) + int'(upd_taken)) % LPT_N;
            end
            m_pov = pred_valid;
            if (pred_valid) begin
                c = m_lpt[m_lht[int'(pred_pc) % LHT_N]];
                m_taken = (c >= CTR_HALF);
                m_conf  = (c == 0) || (c == CTR_MAX);
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        chk("ready", ready, m_ready);
        chk("pred_out_valid", pred_out_valid, m_pov);
        if (m_pov) begin
            chk("pred_taken", pred_taken, m_taken);
            chk("pred_conf", pred_conf, m_conf);
        end
        chk("upd_count", upd_count, m_upd);
        chk("hit_count", hit_count, m_hit);
    end

    task automatic step(input bit pv, input int ppc, input bit uv, input int upc, input bit ut);
        pred_valid = pv;
        pred_pc    = PC_W'(ppc);
        upd_valid  = uv;
        upd_pc     = PC_W'(upc);
        upd_taken  = ut;
        @(posedge clock);
        #1;
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
    endtask

    task automatic rand_step(input int pc_range);
        step(1'($urandom), $urandom_range(pc_range - 1, 0),
             1'($urandom), $urandom_range(pc_range - 1, 0), 1'($urandom));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_pov", pred_out_valid, 0);
        chk("rst_taken", pred_taken, 0);
        chk("rst_conf", pred_conf, 0);
        chk("rst_upd_count", upd_count, 0);
        chk("rst_hit_count", hit_count, 0);
        reset = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 3 * INIT_LEN) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("init_edges", n, INIT_LEN);
    endtask

    task automatic pred_lit(input string name, input int pc, input bit tk, input bit cf);
        step(1, pc, 0, 0, 0);
        chk({name, "_taken"}, pred_taken, tk);
        chk({name, "_conf"}, pred_conf, cf);
        chk({name, "_model_taken"}, m_taken, tk);
    endtask

    initial begin
        reset = 1'b0; pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        @(posedge clock);
        #1;
        pulse_reset();
        wait_ready();
        pred_lit("fresh_pc30", 30, 0, 0);

        // Counter bypass: LPT[0] 3->4 in the same cycle PC 60 reads it.
        step(1, 60, 1, 50, 1);
        chk("cbyp_taken", pred_taken, 1);
        chk("cbyp_conf", pred_conf, 0);

        // History shift: PC 30 now has hist 1 (LPT[1]=3); LPT[0] is 5.
        step(0, 0, 1, 30, 1);
        pred_lit("hshift_pc30", 30, 0, 0);
        pred_lit("hshift_pc31", 31, 1, 0);

        // History bypass: PC 20 must read hist 1 (ctr 3), not hist 0 (ctr 6).
        step(1, 20, 1, 20, 1);
        chk("hbyp_taken", pred_taken, 0);
        chk("hbyp_conf", pred_conf, 0);
        chk("dir_upd_count", upd_count, 3);
        chk("dir_hit_count", hit_count, 2);

        // Training on a freshly swept table.
        pulse_reset();
        wait_ready();
        repeat (12) step(0, 0, 1, 10, 1);
        pred_lit("train12", 10, 1, 0);
        repeat (2) step(0, 0, 1, 10, 1);
        pred_lit("train14", 10, 1, 1);
        chk("train_upd_count", upd_count, 14);
        chk("train_hit_count", hit_count, 3);

        // Randomised traffic: narrow PC range for collisions, then full range.
        for (int i = 0; i < 2000; i++) rand_step(8);
        for (int i = 0; i < 1000; i++) rand_step(1 << PC_W);
        repeat (12) step(0, 0, 1, 10, 1);

        // Reset mid-sweep with traffic that must be ignored, then full re-init.
        pulse_reset();
        for (int i = 0; i < 500; i++) rand_step(16);
        chk("midsweep_ready", ready, 0);
        pulse_reset();
        wait_ready();
        pred_lit("after_reinit_pc10", 10, 0, 0);
        for (int i = 0; i < 500; i++) rand_step(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/local_predictor_param.md
# local_predictor_param

Parametrised local-history branch predictor for the Alpha 21264 tournament predictor. It is the successor to the fixed 10-bit local predictor and sits beside the global predictor and chooser.
- Holds a per-branch local history table (LHT) indexed by PC and a local prediction table (LPT) of saturating counters indexed by history.
- Decouples prediction from resolution and forwards same-cycle updates.
- Clears its tables with a post-reset sweep instead of a bulk reset.
- Keeps hit/update statistics.

## Interface
Parameters:
- PC_W, 10, PC width; must be >= IDX_W
- LHT_ENTRIES, 1024, LHT depth, power of two; IDX_W = $clog2(LHT_ENTRIES)
- HIST_W, 10, history bits per entry; LPT depth = 2**HIST_W
- CTR_W, 3, LPT counter width (>= 2)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- ready  out  1  tables initialised; inputs accepted
- pred_valid  in  1  prediction request
- pred_pc  in  PC_W  branch PC to predict
- pred_out_valid  out  1  pred_taken/pred_conf valid
- pred_taken  out  1  predicted direction
- pred_conf  out  1  counter saturated (0 or max)
- upd_valid  in  1  resolved branch
- upd_pc  in  PC_W  resolved branch PC
- upd_taken  in  1  actual outcome
- upd_count  out  32  resolved updates accepted, saturating
- hit_count  out  32  updates whose pre-update counter MSB equalled upd_taken, saturating

## Operation
- Index: idx = pc[IDX_W-1:0]; hist = LHT[idx]; ctr = LPT[hist]; taken = ctr[CTR_W-1].
- Update (upd_valid & ready):
  - LHT[idx] <= {hist[HIST_W-2:0], upd_taken}.
  - LPT[old hist] increments (taken) or decrements (not taken), saturating at 0 and 2**CTR_W-1.
  - upd_count +1; hit_count +1 if old ctr MSB == upd_taken.
- Prediction (pred_valid & ready): sees the state after this cycle's update (bypass):
  - History is forwarded if upd idx == pred idx.
  - The counter is forwarded if the LPT entry being written equals the LPT entry read with the (possibly forwarded) history.
- Init FSM: INIT -> RUN.
  - Any cycle with reset low: go to INIT and clear the sweep pointer.
  - INIT writes LHT[p]=0 and LPT[p]=2**(CTR_W-1)-1 (weak not-taken; 3 at default), p = 0 .. max(LHT_ENTRIES, 2**HIST_W)-1, one entry per cycle. Out-of-range writes are suppressed.
  - After the last entry: RUN, ready=1.
  - Inputs are ignored while ready=0.
- Reset values: ready=0, pred_out_valid=0, pred_taken=0, pred_conf=0, upd_count=0, hit_count=0.

## Timing
- Prediction latency 1: a request sampled at edge N gives outputs valid after edge N until edge N+1. pred_out_valid = registered (pred_valid & ready).
- An update sampled at edge N is visible to a non-colliding prediction sampled at edge N+1, and to a colliding one at edge N via bypass.
- Init length = max(LHT_ENTRIES, 2**HIST_W) cycles after the first edge with reset high. At default, ready rises after 1024 edges.
- Reset low mid-init or mid-run: next edge forces reset values. Tables are not trusted until the sweep completes again.
- Back-to-back predictions and updates every cycle; no stall.

## Structure
- Package bp_pkg holds:
  - ctr_sat_update(ctr, taken) function
  - weak-not-taken init constant function
  - init FSM state enum
  - shared with the global predictor and chooser
- Sub-module bp_table_init: sweep pointer and INIT/RUN FSM, outputs ready/wr_en/wr_addr. Reusable by the global table.
- Tables are plain arrays (no reset) written by one always_ff.

## Test plan
- Init: release reset, idle -> ready low for 1023 edges, high at edge 1024. A predict of PC 30 gives taken=0, conf=0.
- Training: 14 updates of PC 10 taken, then predict PC 10.
  - After 12 updates: LPT[0x3FF]=5, taken=1, conf=0.
  - After 14 updates: taken=1, conf=1.
  - upd_count=14, hit_count=3.
- History shift: one update of PC 30 taken, then predict PC 30 -> hist=1, LPT[1]=3, taken=0. LPT[0] reads 4.
- Counter bypass: same cycle upd PC 50 taken and pred PC 60 (both hist 0, LPT[0]=3) -> next cycle pred_taken=1.
- History bypass: same cycle upd PC 20 taken and pred PC 20 -> prediction uses hist 1, not 0.
- Reset mid-sweep: drop reset at sweep cycle 500 for 1 cycle -> ready stays low, counters 0, ready rises 1024 edges after release; earlier training is lost.
